bidir_io_bank: RTL and testbench

//  WIDTH-lane registered bidirectional I/O bank: the parametrised successor of the single-bit bidirectional pad path.

---
 rtl/bidir_io_bank.sv | 132 +++++++++++++
 tb/tb_bidir_io_bank.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bidir_io_bank.sv
// rtl/bidir_io_bank.sv - registered bidirectional I/O bank with direction FSM
// Turnaround dead cycles keep the core and the far end from ever co-driving the pads.
module bidir_io_bank #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2,
   parameter int IN_STAGES   = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             mode_req_i,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [WIDTH-1:0] rx_data_o,
   output logic             rx_valid_o,
   output logic             mode_tx_o,
   output logic             busy_o,
   inout  wire  [WIDTH-1:0] bidir_io
);

   typedef enum logic [1:0] {
      ST_RX   = 2'd0,
      ST_TURN = 2'd1,
      ST_TX   = 2'd2
   } state_e;

   localparam int TCW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam int SCW = $clog2(IN_STAGES + 1);
   localparam logic [TCW-1:0] TURN_LOAD  = TCW'(TURN_CYCLES - 1);
   localparam logic [SCW-1:0] SETTLE_MAX = SCW'(IN_STAGES);

   state_e           state_q, state_d;
   state_e           tgt_q, tgt_d;
   logic [TCW-1:0]   turn_cnt_q, turn_cnt_d;
   logic             oe_q, oe_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [SCW-1:0]   settle_q, settle_d;
   logic [WIDTH-1:0] sync_q [IN_STAGES];
   logic             accept;

   // The output buffer is enabled only from the registered OE, so reset releases it at once.
   assign bidir_io  = oe_q ? out_q : {WIDTH{1'bz}};
   assign rx_data_o = sync_q[IN_STAGES-1];

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_RX;
         tgt_q      <= ST_RX;
         turn_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         turn_cnt_q <= turn_cnt_d;
      end
   end

   // Next-state logic; mode_req_i is not looked at while turning.
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      turn_cnt_d = turn_cnt_q;
      unique case (state_q)
         ST_RX: begin
            if (mode_req_i) begin
               state_d    = ST_TURN;
               tgt_d      = ST_TX;
               turn_cnt_d = TURN_LOAD;
            end
         end
         ST_TX: begin
            if (!mode_req_i) begin
               state_d    = ST_TURN;
               tgt_d      = ST_RX;
               turn_cnt_d = TURN_LOAD;
            end
         end
         ST_TURN: begin
            if (turn_cnt_q == '0) begin
               state_d = tgt_q;
            end else begin
               turn_cnt_d = turn_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_RX;
         end
      endcase
   end

   // Output decode from the registered state
   always_comb begin
      mode_tx_o  = (state_q == ST_TX);
      busy_o     = (state_q == ST_TURN);
      tx_ready_o = (state_q == ST_TX) && mode_req_i;
      rx_valid_o = (state_q == ST_RX) && (settle_q == SETTLE_MAX);
   end

   assign accept = tx_valid_i & tx_ready_o;

   always_comb begin
      oe_d  = (state_d == ST_TX);
      out_d = accept ? tx_data_i : out_q;
      if (state_q != ST_RX) begin
         settle_d = '0;
      end else if (settle_q == SETTLE_MAX) begin
         settle_d = settle_q;
      end else begin
         settle_d = settle_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         oe_q     <= 1'b0;
         out_q    <= '0;
         settle_q <= '0;
         for (int i = 0; i < IN_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         oe_q      <= oe_d;
         out_q     <= out_d;
         settle_q  <= settle_d;
         sync_q[0] <= bidir_io;
         for (int i = 1; i < IN_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

endmodule

// File: tb/tb_bidir_io_bank.sv
// tb/tb_bidir_io_bank.sv - scoreboard bench for bidir_io_bank
module tb_bidir_io_bank;

   localparam int W  = 8;
   localparam int TC = 2;
   localparam int IS = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mode_req = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         tx_valid = 1'b0;
   logic         tx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         mode_tx;
   logic         busy;
   wire  [W-1:0] bidir;
   logic         far_en = 1'b1;
   logic [W-1:0] far_data = 8'hA5;

   assign bidir = far_en ? far_data : {W{1'bz}};

   bidir_io_bank #(.WIDTH(W), .TURN_CYCLES(TC), .IN_STAGES(IS)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .mode_req_i (mode_req),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .mode_tx_o  (mode_tx),
      .busy_o     (busy),
      .bidir_io   (bidir)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         mode_tx;
      bit         busy;
      bit         tx_ready;
      bit         rx_valid;
      logic [7:0] rx_data;
      logic [7:0] bus;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: direction letter, cycles spent in the current turn / in receive,
   // last accepted word, and the history of bus values the synchroniser will present.
   byte        m_dir;
   byte        m_tgt;
   int         m_turn_age;
   int         m_rx_age;
   logic [7:0] m_out;
   logic [7:0] hist[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_dir      = "R";
      m_tgt      = "R";
      m_turn_age = 0;
      m_rx_age   = 0;
      m_out      = 8'h00;
      hist.delete();
      for (int i = 0; i < IS; i++) hist.push_back(8'h00);
   endtask

   task automatic do_cycle(input bit mreq, input bit tv, input logic [7:0] td, input logic [7:0] fd);
      exp_t e;
      @(negedge clk);
      rst_n    = 1'b1;
      mode_req = mreq;
      tx_valid = tv;
      tx_data  = td;
      far_en   = (m_dir != "X");
      far_data = fd;
      e.mode_tx  = (m_dir == "X");
      e.busy     = (m_dir == "T");
      e.tx_ready = (m_dir == "X") && mreq;
      e.rx_valid = (m_dir == "R") && (m_rx_age >= IS);
      e.rx_data  = hist[IS-1];
      e.bus      = (m_dir == "X") ? m_out : fd;
      sb.push_back(e);
      @(posedge clk);
      if (e.tx_ready && tv) m_out = td;
      hist.push_front(e.bus);
      void'(hist.pop_back());
      case (m_dir)
         "R": if (mreq) begin m_dir = "T"; m_tgt = "X"; m_turn_age = 0; end
              else m_rx_age++;
         "X": if (!mreq) begin m_dir = "T"; m_tgt = "R"; m_turn_age = 0; end
         default: begin
            if (m_turn_age == TC - 1) begin
               m_dir = m_tgt;
               if (m_tgt == "R") m_rx_age = 0;
            end else begin
               m_turn_age++;
            end
         end
      endcase
   endtask

   // Asynchronous reset between clock edges; checked before any edge arrives.
   task automatic mid_reset();
      #3;
      rst_n    = 1'b0;
      far_en   = 1'b1;
      far_data = 8'h5A;
      #1;
      chk("async_bus_released", bidir, 8'h5A);
      chk("async_tx_ready", tx_ready, 0);
      chk("async_mode_tx", mode_tx, 0);
      chk("async_busy", busy, 0);
      chk("async_rx_valid", rx_valid, 0);
      m_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mode_tx", mode_tx, e.mode_tx);
            chk("busy", busy, e.busy);
            chk("tx_ready", tx_ready, e.tx_ready);
            chk("rx_valid", rx_valid, e.rx_valid);
            if (e.rx_valid) chk("rx_data", rx_data, e.rx_data);
            chk("bus", bidir, e.bus);
         end
      end
   end

   initial begin : stim
      bit mr;
      m_reset();
      #2;
      chk("rst_bus_released", bidir, 8'hA5);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_mode_tx", mode_tx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_ready", tx_ready, 0);
      #20;
      repeat (4) do_cycle(0, 0, 8'h00, 8'hA5);
      repeat (3) do_cycle(1, 1, 8'hEE, 8'hA5);
      do_cycle(1, 1, 8'h3C, 8'h00);
      do_cycle(1, 0, 8'h00, 8'h00);
      do_cycle(1, 1, 8'h01, 8'h00);
      do_cycle(1, 1, 8'h02, 8'h00);
      do_cycle(1, 1, 8'h03, 8'h00);
      repeat (2) do_cycle(1, 0, 8'h99, 8'h00);
      do_cycle(0, 1, 8'h77, 8'h00);
      repeat (5) do_cycle(0, 1, 8'h66, 8'hC3);
      do_cycle(1, 0, 8'h00, 8'h11);
      do_cycle(0, 0, 8'h00, 8'h22);
      repeat (8) do_cycle(0, 0, 8'h00, 8'h33);
      repeat (3) do_cycle(1, 0, 8'h00, 8'h44);
      do_cycle(1, 1, 8'hFF, 8'h00);
      do_cycle(1, 0, 8'h00, 8'h00);
      mid_reset();
      repeat (5) do_cycle(1, 0, 8'h00, 8'h55);
      mr = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) mr = ~mr;
         do_cycle(mr, 1'($urandom), 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 499) == 0) mid_reset();
      end
      repeat (2) do_cycle(0, 0, 8'h00, 8'h00);
      @(negedge clk);
      #3;
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
